// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the 8N1 UART receiver.
// The slave modport is the receiver; the master modport is the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling from a clock-divided
// bit timer, LSB-first deserialisation, one-cycle rx_valid / frame_err pulses.
module uart_rx #(
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned CLOCK_SPEED = 50_000_000
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
  localparam int unsigned HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int unsigned CW         = $clog2(BAUD_WIDTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_WIDTH - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          busy_q;

  assign rx_s          = sync[1];
  assign bus.data      = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

  // Synchroniser, bit timer, frame FSM and registered outputs.
  // busy is updated on every transition alongside state so it tracks state != IDLE
  // without a combinational decode on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync    <= {sync[0], bus.rx};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_q  <= shift;
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
              state  <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
